bnn_layer_sequencer: RTL

- Central controller for the BNN inference datapath (memory read port, xnor_popcount, Accumulator, Comparator, pooling/final register).
- On iSTART it steps through CONV1, CONV2, CONV3, FCL1 and FCL2.
- For each layer it issues read addresses, accumulate, compare and pool strobes, writes result bits into the 112-bit final register, and writes the register back to memory.
- Pulses oDONE after FCL2.

---
 rtl/bnn_layer_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer
// Central controller for the BNN inference datapath. On iSTART it walks the layers
// CONV1, CONV2, CONV3, FCL1 and FCL2. For each layer it streams read addresses, strobes the
// accumulator, comparator and pooling logic, writes result bits into the 112-bit final
// register, and writes that register back to memory. oDONE pulses for one cycle after FCL2.
//
// Ports
//   iCLK, iRST            clock, synchronous active-high reset
//   iCLR                  synchronous abort to IDLE
//   iSTART                start one inference (sampled only in IDLE)
//   oLAYER                0 IDLE, 1 CONV1, 2 CONV2, 3 CONV3, 4 FCL1, 5 FCL2
//   oMEM_SEL              read source (0 MEM0, 1 MEM1)
//   oRd_EN, oRd_ADDR      memory read strobe and address
//   oAcc_EN, oAcc_CLR     accumulator add / clear-after-sample
//   oCmp_EN, oPool_FIRST  comparator sample, first compare of a pool window
//   oRegWr_EN, oReg_ADDR  final register bit write and bit address
//   oRegRd_EN             final register write-back strobe
//   oMem0_WE, oMem1_WE    write-back target (MEM0 for FCL2, MEM1 otherwise)
//   oBUSY, oDONE          not idle / end-of-inference pulse
module bnn_layer_sequencer #(
  parameter int unsigned AW        = 12,
  parameter int unsigned RAW       = 7,
  parameter int unsigned CONV_ACC  = 9,
  parameter int unsigned FCL_ACC   = 12,
  parameter int unsigned CONV_NOUT = 112,
  parameter int unsigned FCL1_NOUT = 112,
  parameter int unsigned FCL2_NOUT = 8,
  parameter int unsigned POOL      = 4,
  parameter int unsigned LAT       = 2
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iCLR,
  input  logic           iSTART,
  output logic [2:0]     oLAYER,
  output logic           oMEM_SEL,
  output logic           oRd_EN,
  output logic [AW-1:0]  oRd_ADDR,
  output logic           oAcc_EN,
  output logic           oAcc_CLR,
  output logic           oCmp_EN,
  output logic           oPool_FIRST,
  output logic           oRegWr_EN,
  output logic [RAW-1:0] oReg_ADDR,
  output logic           oRegRd_EN,
  output logic           oMem0_WE,
  output logic           oMem1_WE,
  output logic           oBUSY,
  output logic           oDONE
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StConv1 = 3'd1,
    StConv2 = 3'd2,
    StConv3 = 3'd3,
    StFcl1  = 3'd4,
    StFcl2  = 3'd5,
    StDone  = 3'd6
  } layer_e;

  typedef enum logic [2:0] {
    PhRead  = 3'd0,
    PhDrain = 3'd1,
    PhCmp   = 3'd2,
    PhFlush = 3'd3,
    PhWb    = 3'd4
  } phase_e;

  layer_e         layer_q, layer_d;
  phase_e         phase_q, phase_d;
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CW-1:0]  pool_cnt_q, pool_cnt_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [RAW-1:0] reg_addr_q, reg_addr_d;
  logic           reg_wr_q, reg_wr_d;

  logic           active;
  logic           is_conv;
  logic [CW-1:0]  acc_n;
  logic [CW-1:0]  pw_n;
  logic [RAW-1:0] nout_last;

  // Per-layer settings.
  always_comb begin
    active  = (layer_q != StIdle) && (layer_q != StDone);
    is_conv = (layer_q == StConv1) || (layer_q == StConv2) || (layer_q == StConv3);
    acc_n   = is_conv ? CW'(CONV_ACC) : CW'(FCL_ACC);
    pw_n    = is_conv ? CW'(POOL) : CW'(1);
    case (layer_q)
      StFcl1:  nout_last = RAW'(FCL1_NOUT - 1);
      StFcl2:  nout_last = RAW'(FCL2_NOUT - 1);
      default: nout_last = RAW'(CONV_NOUT - 1);
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      layer_q    <= StIdle;
      phase_q    <= PhRead;
      acc_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      pool_cnt_q <= '0;
      rd_addr_q  <= '0;
      reg_addr_q <= '0;
      reg_wr_q   <= 1'b0;
    end else begin
      layer_q    <= layer_d;
      phase_q    <= phase_d;
      acc_cnt_q  <= acc_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      pool_cnt_q <= pool_cnt_d;
      rd_addr_q  <= rd_addr_d;
      reg_addr_q <= reg_addr_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  always_comb begin
    layer_d    = layer_q;
    phase_d    = phase_q;
    acc_cnt_d  = acc_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    pool_cnt_d = pool_cnt_q;
    rd_addr_d  = rd_addr_q;
    reg_addr_d = reg_addr_q;
    reg_wr_d   = 1'b0;

    // Bit address advances after its write pulse but saturates at the layer's last bit.
    if (reg_wr_q && (reg_addr_q != nout_last)) begin
      reg_addr_d = reg_addr_q + 1'b1;
    end

    unique case (layer_q)
      StIdle: begin
        if (iSTART) begin
          layer_d    = StConv1;
          phase_d    = PhRead;
          acc_cnt_d  = '0;
          lat_cnt_d  = '0;
          pool_cnt_d = '0;
          rd_addr_d  = '0;
          reg_addr_d = '0;
        end
      end
      StDone: begin
        layer_d = StIdle;
      end
      default: begin
        unique case (phase_q)
          PhRead: begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (acc_cnt_q == acc_n - 1'b1) begin
              acc_cnt_d = '0;
              phase_d   = (LAT == 0) ? PhCmp : PhDrain;
            end else begin
              acc_cnt_d = acc_cnt_q + 1'b1;
            end
          end
          PhDrain: begin
            if (lat_cnt_q == CW'(LAT) - 1'b1) begin
              lat_cnt_d = '0;
              phase_d   = PhCmp;
            end else begin
              lat_cnt_d = lat_cnt_q + 1'b1;
            end
          end
          PhCmp: begin
            if (pool_cnt_q == pw_n - 1'b1) begin
              // Window closed: reg_addr_q still names the bit this window produces.
              pool_cnt_d = '0;
              reg_wr_d   = 1'b1;
              phase_d    = (reg_addr_q == nout_last) ? PhFlush : PhRead;
            end else begin
              pool_cnt_d = pool_cnt_q + 1'b1;
              phase_d    = PhRead;
            end
          end
          PhFlush: begin
            phase_d = PhWb;
          end
          PhWb: begin
            phase_d    = PhRead;
            rd_addr_d  = '0;
            reg_addr_d = '0;
            layer_d    = (layer_q == StFcl2) ? StDone : layer_e'(layer_q + 3'd1);
          end
          default: begin
            phase_d = PhRead;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    oLAYER      = 3'd0;
    oMEM_SEL    = 1'b0;
    oRd_EN      = 1'b0;
    oCmp_EN     = 1'b0;
    oAcc_CLR    = 1'b0;
    oPool_FIRST = 1'b0;
    oRegRd_EN   = 1'b0;
    oMem0_WE    = 1'b0;
    oMem1_WE    = 1'b0;
    if (active) begin
      oLAYER      = layer_q;
      oMEM_SEL    = (layer_q != StConv1);
      oRd_EN      = (phase_q == PhRead);
      oCmp_EN     = (phase_q == PhCmp);
      oAcc_CLR    = (phase_q == PhCmp);
      oPool_FIRST = (phase_q == PhCmp) && (pool_cnt_q == '0);
      oRegRd_EN   = (phase_q == PhWb);
      oMem0_WE    = (phase_q == PhWb) && (layer_q == StFcl2);
      oMem1_WE    = (phase_q == PhWb) && (layer_q != StFcl2);
    end
    oRegWr_EN = reg_wr_q;
    oRd_ADDR  = rd_addr_q;
    oReg_ADDR = reg_addr_q;
    oBUSY     = (layer_q != StIdle);
    oDONE     = (layer_q == StDone);
  end

  // Read strobe delayed by the memory + popcount latency.
  if (LAT == 0) begin : g_no_lat
    assign oAcc_EN = oRd_EN;
  end else begin : g_lat
    logic [LAT-1:0] acc_dly_q;
    always_ff @(posedge iCLK) begin
      if (iRST || iCLR) begin
        acc_dly_q <= '0;
      end else begin
        acc_dly_q <= (acc_dly_q << 1) | LAT'(oRd_EN);
      end
    end
    assign oAcc_EN = acc_dly_q[LAT-1];
  end

endmodule
